// File: rtl/wb_stage_ext.sv
// MEM/WB pipeline register with sub-word load extension, result select and retire counter.
// One cycle from in_* to wb_*; stall holds the stage, flush inserts a bubble.
module wb_stage_ext #(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int PC_OFFSET = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_we,
  input  logic [AW-1:0]    in_rd,
  input  logic [1:0]       in_wb_src,
  input  logic [2:0]       in_ld_type,
  input  logic [1:0]       in_byte_off,
  input  logic [DW-1:0]    in_pc,
  input  logic [DW-1:0]    in_alu,
  input  logic [DW-1:0]    in_dm,
  input  logic [DW-1:0]    in_md,
  output logic             wb_valid,
  output logic             wb_we,
  output logic [AW-1:0]    wb_rd,
  output logic [DW-1:0]    wb_data,
  output logic [DW-1:0]    wb_pc,
  output logic [CNT_W-1:0] retired
);

  localparam logic [DW-1:0] PC_OFF = DW'(PC_OFFSET);

  localparam logic [2:0] LD_LBU = 3'd1;
  localparam logic [2:0] LD_LB  = 3'd2;
  localparam logic [2:0] LD_LHU = 3'd3;
  localparam logic [2:0] LD_LH  = 3'd4;

  logic             valid_q, we_q;
  logic [AW-1:0]    rd_q;
  logic [1:0]       src_q;
  logic [2:0]       ld_q;
  logic [1:0]       off_q;
  logic [DW-1:0]    pc_q, alu_q, dm_q, md_q;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [DW-1:0]    ld_v;
  logic [DW-1:0]    data_d;

  assign retired_d = retired_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      src_q     <= '0;
      ld_q      <= '0;
      off_q     <= '0;
      pc_q      <= '0;
      alu_q     <= '0;
      dm_q      <= '0;
      md_q      <= '0;
      retired_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      we_q    <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_valid;
      we_q    <= in_we;
      rd_q    <= in_rd;
      src_q   <= in_wb_src;
      ld_q    <= in_ld_type;
      off_q   <= in_byte_off;
      pc_q    <= in_pc;
      alu_q   <= in_alu;
      dm_q    <= in_dm;
      md_q    <= in_md;
      if (in_valid) retired_q <= retired_d;
    end
  end

  // Halfword select uses only off[1]; odd offsets are filtered upstream.
  always_comb begin
    byte_v = dm_q[7:0];
    case (off_q)
      2'd1:    byte_v = dm_q[15:8];
      2'd2:    byte_v = dm_q[23:16];
      2'd3:    byte_v = dm_q[31:24];
      default: byte_v = dm_q[7:0];
    endcase
    half_v = off_q[1] ? dm_q[31:16] : dm_q[15:0];

    case (ld_q)
      LD_LBU:  ld_v = {{(DW-8){1'b0}}, byte_v};
      LD_LB:   ld_v = {{(DW-8){byte_v[7]}}, byte_v};
      LD_LHU:  ld_v = {{(DW-16){1'b0}}, half_v};
      LD_LH:   ld_v = {{(DW-16){half_v[15]}}, half_v};
      default: ld_v = dm_q;
    endcase

    case (src_q)
      2'd1:    data_d = ld_v;
      2'd2:    data_d = pc_q + PC_OFF;
      2'd3:    data_d = md_q;
      default: data_d = alu_q;
    endcase
  end

  assign wb_valid = valid_q;
  assign wb_we    = valid_q & we_q & (rd_q != '0);
  assign wb_rd    = rd_q;
  assign wb_data  = data_d;
  assign wb_pc    = pc_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage_ext.sv
// Directed bench for wb_stage_ext: default instance plus a 4-bit-counter instance sharing stimulus.
module tb_wb_stage_ext;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_src;
  logic [2:0]  in_ld_type;
  logic [1:0]  in_byte_off;
  logic [31:0] in_pc, in_alu, in_dm, in_md;

  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, wb_pc, retired;

  logic        s_valid, s_we;
  logic [4:0]  s_rd;
  logic [31:0] s_data, s_pc;
  logic [3:0]  s_retired;

  int n_vec = 0;
  int n_bad = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  wb_stage_ext u_dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_wb_src(in_wb_src),
    .in_ld_type(in_ld_type), .in_byte_off(in_byte_off), .in_pc(in_pc),
    .in_alu(in_alu), .in_dm(in_dm), .in_md(in_md),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_pc(wb_pc), .retired(retired)
  );

  wb_stage_ext #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_rd(in_rd), .in_wb_src(in_wb_src),
    .in_ld_type(in_ld_type), .in_byte_off(in_byte_off), .in_pc(in_pc),
    .in_alu(in_alu), .in_dm(in_dm), .in_md(in_md),
    .wb_valid(s_valid), .wb_we(s_we), .wb_rd(s_rd), .wb_data(s_data),
    .wb_pc(s_pc), .retired(s_retired)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // Advances one edge; the counter model follows reset > flush > stall > capture.
  task automatic tick();
    if (reset) exp_ret = 0;
    else if (!flush && !stall && in_valid) exp_ret++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag);
    chk({tag, "_ret"}, retired, 32'(exp_ret));
    chk({tag, "_ret4"}, 32'(s_retired), 32'(exp_ret % 16));
  endtask

  task automatic ld(input string tag, input logic [2:0] t, input logic [1:0] off,
                    input logic [31:0] exp);
    in_wb_src   = 2'd1;
    in_rd       = 5'd3;
    in_ld_type  = t;
    in_byte_off = off;
    tick();
    chk(tag, wb_data, exp);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd5; in_wb_src = 2'd0;
    in_ld_type = 3'd0; in_byte_off = 2'd0;
    in_pc = 32'h0; in_alu = 32'h0; in_dm = 32'h0; in_md = 32'h0;

    tick(); tick();
    chk("rst_valid", 32'(wb_valid), 32'd0);
    chk("rst_we",    32'(wb_we),    32'd0);
    chk("rst_data",  wb_data,       32'd0);
    chk("rst_pc",    wb_pc,         32'd0);
    chk_ret("rst");

    reset = 1'b0;
    tick();
    chk("cap_rd",    32'(wb_rd),    32'd5);
    chk("cap_valid", 32'(wb_valid), 32'd1);
    chk("cap_we",    32'(wb_we),    32'd1);
    chk("cap_ret",   retired,       32'd1);

    in_dm = 32'h8001_7FF0;
    ld("lb_off0",   3'd2, 2'd0, 32'hFFFF_FFF0);
    ld("lbu_off1",  3'd1, 2'd1, 32'h0000_007F);
    ld("lb_off3",   3'd2, 2'd3, 32'hFFFF_FF80);
    ld("lh_off2",   3'd4, 2'd2, 32'hFFFF_8001);
    ld("lh_off3",   3'd4, 2'd3, 32'hFFFF_8001);
    ld("lhu_off0",  3'd3, 2'd0, 32'h0000_7FF0);
    ld("lw",        3'd0, 2'd2, 32'h8001_7FF0);
    ld("ld_type5",  3'd5, 2'd1, 32'h8001_7FF0);
    ld("lbu_off2",  3'd1, 2'd2, 32'h0000_0001);

    in_wb_src = 2'd2; in_pc = 32'h0000_3000;
    tick();
    chk("link",    wb_data, 32'h0000_3008);
    chk("link_pc", wb_pc,   32'h0000_3000);
    in_pc = 32'hFFFF_FFFC;
    tick();
    chk("link_wrap", wb_data, 32'h0000_0004);

    in_wb_src = 2'd0; in_rd = 5'd7; in_alu = 32'hAAAA_0001; in_pc = 32'h0000_0100;
    tick();
    chk("a_rd", 32'(wb_rd), 32'd7);
    chk_ret("a");
    stall = 1'b1; in_rd = 5'd9; in_alu = 32'hBBBB_0002; in_pc = 32'h0000_0200;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rd",   32'(wb_rd), 32'd7);
      chk("stall_data", wb_data,    32'hAAAA_0001);
      chk("stall_pc",   wb_pc,      32'h0000_0100);
      chk_ret("stall");
    end
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(wb_valid), 32'd0);
    chk("flush_we",    32'(wb_we),    32'd0);
    chk_ret("flush");
    stall = 1'b0; flush = 1'b0;
    tick();
    chk("b_rd",   32'(wb_rd), 32'd9);
    chk("b_data", wb_data,    32'hBBBB_0002);

    in_we = 1'b1; in_rd = 5'd0; in_wb_src = 2'd3; in_md = 32'h1234_5678;
    tick();
    chk("r0_we",    32'(wb_we),    32'd0);
    chk("r0_valid", 32'(wb_valid), 32'd1);
    chk("md_data",  wb_data,       32'h1234_5678);

    stall = 1'b1; reset = 1'b1; in_valid = 1'b1;
    tick();
    chk("rst_stall_valid", 32'(wb_valid), 32'd0);
    chk_ret("rst_stall");
    stall = 1'b0; reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_rd = 5'(i + 1);
      tick();
      chk_ret("wrap_cap");
      in_valid = 1'b0;
      tick();
      chk_ret("wrap_idle");
    end
    chk("wrap4_zero", 32'(s_retired), 32'd0);
    chk("wrap32_16",  retired,        32'd16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
